// File: rtl/csa_pkg.sv
// Shared definitions for the sequential carry-select adder controller:
// slice width, FSM state encoding and a constant log2 helper.
package csa_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/select.sv
// 4-bit carry-select slice: both carry-in cases are summed in parallel and the
// real carry-in picks one.
module select
    import csa_pkg::*;
(
    input  logic [SLICE_W-1:0] X,
    input  logic [SLICE_W-1:0] Y,
    input  logic               Cin,
    output logic [SLICE_W-1:0] sum,
    output logic               Cout
);

    logic [SLICE_W:0] res_c0;
    logic [SLICE_W:0] res_c1;

    assign res_c0      = {1'b0, X} + {1'b0, Y};
    assign res_c1      = {1'b0, X} + {1'b0, Y} + (SLICE_W+1)'(1);
    assign {Cout, sum} = Cin ? res_c1 : res_c0;

endmodule

// File: rtl/csa_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder: one carry-select slice is reused nibble by nibble,
// LS nibble first, with the slice carry registered between passes.
module csa_seq_ctrl
    import csa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = (clog2(NSLICE) < 1) ? 1 : clog2(NSLICE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    state_e                   state_q, state_d;
    logic [WIDTH-1:0]         a_sh_q, a_sh_d;
    logic [WIDTH-1:0]         b_sh_q, b_sh_d;
    logic [WIDTH-1:0]         sum_sh_q, sum_sh_d;
    logic                     carry_q, carry_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [SLICE_W-1:0]       nib;
    logic                     nib_cout;
    logic [WIDTH+SLICE_W-1:0] sum_cat;
    logic                     accept;
    logic                     last;

    assign accept  = in_valid && (state_q == IDLE);
    assign last    = (cnt_q == CNT_LAST);
    // New nibble enters at the MSB end; after NSLICE passes the sum is aligned.
    assign sum_cat = {nib, sum_sh_q};

    select u_slice (
        .X    (a_sh_q[SLICE_W-1:0]),
        .Y    (b_sh_q[SLICE_W-1:0]),
        .Cin  (carry_q),
        .sum  (nib),
        .Cout (nib_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
        sum       = (state_q == DONE) ? sum_sh_q : '0;
        cout      = (state_q == DONE) && carry_q;
    end

    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        if (accept) begin
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = cin;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_sh_d   = a_sh_q >> SLICE_W;
            b_sh_d   = b_sh_q >> SLICE_W;
            sum_sh_d = sum_cat[WIDTH+SLICE_W-1:SLICE_W];
            carry_d  = nib_cout;
            if (!last) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Bench for csa_seq_ctrl: directed handshake/latency/reset cases at WIDTH=16, then
// random traffic at WIDTH=4/16/32 scored against plain a+b+cin arithmetic.
module tb_csa_seq_ctrl;

    localparam int NV = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [15:0] a, b, sum;
    int          checks = 0;
    int          errors = 0;
    bit          go = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    csa_seq_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic);
        @(negedge clk);
        a = ia; b = ib; cin = ic; in_valid = 1'b1;
        chk("acc_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        chk("acc_busy", busy, 1);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    int lat;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: carry ripples across every nibble; latency and one-cycle out_valid
        out_ready = 1'b1;
        issue(16'h0001, 16'hFFFF, 1'b0);
        wait_out(lat);
        chk("t1_latency", lat, 4);
        chk("t1_sum", sum, 16'h0000);
        chk("t1_cout", cout, 1);
        @(posedge clk); #1;
        chk("t1_ov_drop", out_valid, 0);
        chk("t1_idle", in_ready, 1);

        // 2: busy from accept until handshake
        issue(16'h1234, 16'h4321, 1'b1);
        wait_out(lat);
        chk("t2_latency", lat, 4);
        chk("t2_sum", sum, 16'h5556);
        chk("t2_cout", cout, 0);
        chk("t2_busy_done", busy, 1);
        @(posedge clk); #1;
        chk("t2_busy_after", busy, 0);

        // 3: back-pressure holds the result
        out_ready = 1'b0;
        issue(16'h8000, 16'h8000, 1'b1);
        wait_out(lat);
        chk("t3_latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t3_ov_hold", out_valid, 1);
            chk("t3_sum_hold", sum, 16'h0001);
            chk("t3_cout_hold", cout, 1);
            chk("t3_in_ready", in_ready, 0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_released", out_valid, 0);
        chk("t3_idle", in_ready, 1);

        // 4: request raised during RUN waits until IDLE
        issue(16'h0F0F, 16'h0101, 1'b0);
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        wait_out(lat);
        chk("t4_first_sum", sum, 16'h1010);
        chk("t4_first_cout", cout, 0);
        @(posedge clk); #1;
        chk("t4_idle", in_ready, 1);
        chk("t4_no_repeat", out_valid, 0);
        @(posedge clk); #1;
        chk("t4_second_acc", busy, 1);
        in_valid = 1'b0; a = 16'h5A5A; b = 16'hA5A5;
        wait_out(lat);
        chk("t4_second_lat", lat, 4);
        chk("t4_second_sum", sum, 16'h0000);
        chk("t4_second_cout", cout, 1);
        @(posedge clk); #1;

        // 5: reset mid-RUN aborts
        issue(16'hAAAA, 16'h5555, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1;
        #1;
        chk("t5_ov", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("t5_ignored", busy, 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        issue(16'h00FF, 16'h0001, 1'b0);
        wait_out(lat);
        chk("t5_latency", lat, 4);
        chk("t5_sum", sum, 16'h0100);
        chk("t5_cout", cout, 0);
        @(posedge clk); #1;

        go = 1'b1;
        wait (g_rnd[0].done && g_rnd[1].done && g_rnd[2].done);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int W = (g == 0) ? 4 : (g == 1) ? 16 : 32;

        logic         iv, ir, ci, ov, ordy, co, bz;
        logic [W-1:0] ra, rb, rs;
        logic [W:0]   q[$];
        bit           done = 1'b0;

        csa_seq_ctrl #(.WIDTH(W)) u_dut (
            .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
            .a(ra), .b(rb), .cin(ci), .out_valid(ov), .out_ready(ordy),
            .sum(rs), .cout(co), .busy(bz)
        );

        initial begin
            logic [W-1:0] xa, xb;
            logic         xc;
            int           t;
            iv = 1'b0; ra = '0; rb = '0; ci = 1'b0;
            wait (go);
            for (int i = 0; i < NV; i++) begin
                @(negedge clk);
                xa = W'({$urandom, $urandom});
                xb = W'({$urandom, $urandom});
                xc = 1'($urandom);
                ra = xa; rb = xb; ci = xc; iv = 1'b1;
                t = 0;
                while (!ir && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                if (!ir) chk($sformatf("rnd%0d_accept_timeout", W), 0, 1);
                else     q.push_back({1'b0, xa} + {1'b0, xb} + (W+1)'(xc));
                @(posedge clk); #1;
                iv = 1'b0;
                ra = W'({$urandom, $urandom}); rb = W'({$urandom, $urandom}); ci = 1'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        initial begin
            int got;
            int cyc;
            logic [W:0] e;
            got = 0; cyc = 0; ordy = 1'b0;
            wait (go);
            while (got < NV && cyc < 50000) begin
                @(negedge clk);
                cyc++;
                ordy = ($urandom_range(0, 3) != 0);
                if (ov && ordy) begin
                    if (q.size() == 0) begin
                        chk($sformatf("rnd%0d_unexpected", W), {co, rs}, 0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("rnd%0d_result", W), {co, rs}, e);
                    end
                    got++;
                end
            end
            chk($sformatf("rnd%0d_count", W), got, NV);
            repeat (3) @(negedge clk);
            chk($sformatf("rnd%0d_leftover", W), q.size(), 0);
            done = 1'b1;
        end
    end

endmodule
